// File: rtl/uart_loop_ctrl.sv
// UART loopback controller: buffers received bytes in a small FIFO and replays
// them to the transmitter one at a time through a start/busy handshake.
module uart_loop_ctrl #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  input  logic        tx_busy,
  output logic [15:0] uart_cnt,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic [4:0]  fifo_cnt,
  output logic        overflow
);

  // state     | meaning
  // IDLE      | waiting for a buffered byte and an idle transmitter
  // LOAD      | pop head byte into tx_data
  // START     | tx_en pulse
  // WAIT_BUSY | waiting for transmitter to report busy (16-cycle timeout)
  // WAIT_DONE | waiting for transmitter to finish
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] WAIT_BUSY = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] FULL_CNT = 5'(DEPTH);
  localparam logic [3:0] TMO_LOAD = 4'd15;

  logic [2:0]    state;
  logic [3:0]    tmo_cnt;
  logic          rx_done_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    mem [DEPTH];

  logic push;
  logic pop;
  logic full;
  logic push_acc;

  assign uart_cnt = 16'(CLK_FREQ / BAUD);

  assign push     = rx_done && !rx_done_q;
  assign pop      = (state == LOAD);
  assign full     = (fifo_cnt == FULL_CNT);
  // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
  assign push_acc = push && (!full || pop);
  assign tx_en    = (state == START);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_done_q <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_acc, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 5'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 5'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push && !push_acc) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx_data <= 8'h00;
      tmo_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_cnt != 5'd0 && !tx_busy) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          tx_data <= mem[rd_ptr];
          state   <= START;
        end
        START: begin
          tmo_cnt <= TMO_LOAD;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (tmo_cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - 4'd1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loop_ctrl.sv
// Directed bench for uart_loop_ctrl at default parameters: latency, burst,
// overflow, long rx_done, busy timeout and mid-transfer reset.
module tb_uart_loop_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic [15:0] uart_cnt;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic [4:0]  fifo_cnt;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  logic [7:0] tx_log[$];

  uart_loop_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .tx_busy  (tx_busy),
    .uart_cnt (uart_cnt),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .fifo_cnt (fifo_cnt),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Values seen here are the pre-edge ones, i.e. what was presented during the cycle.
  always @(posedge clk) begin
    if (tx_en) tx_log.push_back(tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    step();
    rx_done = 1'b0;
    step();
  endtask

  // Returns the number of negedges until tx_en is seen high, or -1 on timeout.
  task automatic wait_tx(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (tx_en) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int gap;
    rst     = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    tx_busy = 1'b0;
    step(3);
    chk("rst_uart_cnt", 32'(uart_cnt), 32'd434);
    chk("rst_tx_en",    32'(tx_en),    32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'h00);
    chk("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // single byte, pushed on the first edge after reset release
    rst     = 1'b0;
    rx_done = 1'b1;
    rx_data = 8'h5A;
    step();
    chk("single_cnt_after_push", 32'(fifo_cnt), 32'd1);
    rx_done = 1'b0;
    step();
    chk("single_load_no_en", 32'(tx_en), 32'd0);
    step();
    chk("single_tx_en",   32'(tx_en),    32'd1);
    chk("single_tx_data", 32'(tx_data),  32'h5A);
    chk("single_cnt_pop", 32'(fifo_cnt), 32'd0);
    tx_busy = 1'b1;
    step(10);
    tx_busy = 1'b0;
    step(3);
    chk("single_log_size", 32'(tx_log.size()), 32'd1);

    // burst while transmitter busy, then timed-out handshakes
    tx_busy = 1'b1;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    chk("burst_cnt", 32'(fifo_cnt), 32'd3);
    chk("burst_held", 32'(tx_log.size()), 32'd1);
    tx_busy = 1'b0;
    wait_tx(40, gap);
    chk("burst_gap0", 32'(gap), 32'd2);
    chk("burst_b0", 32'(tx_data), 32'h11);
    wait_tx(40, gap);
    chk("timeout_gap1", 32'(gap), 32'd19);
    chk("burst_b1", 32'(tx_data), 32'h22);
    wait_tx(40, gap);
    chk("timeout_gap2", 32'(gap), 32'd19);
    chk("burst_b2", 32'(tx_data), 32'h33);
    step(25);
    chk("burst_cnt_end", 32'(fifo_cnt), 32'd0);
    chk("burst_log_size", 32'(tx_log.size()), 32'd4);

    // overflow: DEPTH+1 pushes while busy
    tx_busy = 1'b1;
    for (int i = 0; i < 9; i++) push(8'h80 + 8'(i));
    chk("ovf_cnt", 32'(fifo_cnt), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    tx_busy = 1'b0;
    step(8 * 19 + 10);
    chk("ovf_log_size", 32'(tx_log.size()), 32'd12);
    chk("ovf_first", 32'(tx_log[4]), 32'h80);
    chk("ovf_last", 32'(tx_log[11]), 32'h87);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_cnt_end", 32'(fifo_cnt), 32'd0);

    // rx_done held for five cycles pushes once
    rx_done = 1'b1;
    rx_data = 8'hA5;
    step(5);
    rx_done = 1'b0;
    step(30);
    chk("long_log_size", 32'(tx_log.size()), 32'd13);
    chk("long_byte", 32'(tx_log[12]), 32'hA5);
    chk("long_cnt", 32'(fifo_cnt), 32'd0);

    // reset while in WAIT_DONE with two bytes queued
    push(8'h01);
    tx_busy = 1'b1;
    step(3);
    push(8'h02);
    push(8'h03);
    chk("mid_cnt", 32'(fifo_cnt), 32'd2);
    chk("mid_log_size", 32'(tx_log.size()), 32'd14);
    rst = 1'b1;
    step();
    chk("mid_rst_tx_en",    32'(tx_en),    32'd0);
    chk("mid_rst_tx_data",  32'(tx_data),  32'h00);
    chk("mid_rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    rst     = 1'b0;
    tx_busy = 1'b0;
    step(40);
    chk("mid_no_tx", 32'(tx_log.size()), 32'd14);
    chk("mid_cnt_end", 32'(fifo_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_loop_ctrl.md
UART_LOOP_CTRL -- requirements
Module: uart_loop_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have parameter DEPTH, default 8, byte FIFO depth (power of 2, 2..16).
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rx_done  input  1  receiver byte-complete flag, may stay high for one or more cycles.
REQ-007 SHALL have port rx_data  input  8  received byte, valid while rx_done is high.
REQ-008 SHALL have port tx_busy  input  1  transmitter busy flag.
REQ-009 SHALL have port uart_cnt  output  16  baud divider to receiver and transmitter, CLK_FREQ/BAUD truncated to 16 bits (434 at defaults).
REQ-010 SHALL have port tx_en  output  1  one-cycle transmit start pulse.
REQ-011 SHALL have port tx_data  output  8  byte to transmit, stable from tx_en high until FSM returns to IDLE.
REQ-012 SHALL have port fifo_cnt  output  5  bytes currently buffered, 0..DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky flag, a received byte was dropped.

Function
REQ-014 uart_cnt SHALL be a constant derived from the parameters, independent of reset.
REQ-015 Push event SHALL be rx_done rising edge: rx_done=1 at the current edge and 0 at the previous edge (one register, reset to 0). A multi-cycle rx_done high SHALL push exactly once.
REQ-016 On a push with fifo_cnt<DEPTH, rx_data sampled at that edge SHALL be written to FIFO; fifo_cnt increments at that edge.
REQ-017 On a push with fifo_cnt==DEPTH and no pop at the same edge, the byte SHALL be dropped, overflow set to 1, FIFO contents and fifo_cnt unchanged.
REQ-018 Push and pop at the same edge SHALL both take effect; fifo_cnt unchanged; when full this is not an overflow.
REQ-019 FIFO SHALL be first-in first-out; read/write pointers wrap modulo DEPTH.
REQ-020 FSM states SHALL be IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE -> LOAD when fifo_cnt>0 and tx_busy==0; otherwise stay.
REQ-022 LOAD -> START unconditionally; at this edge head byte is popped into tx_data.
REQ-023 START: tx_en=1 for exactly this one cycle; -> WAIT_BUSY.
REQ-024 WAIT_BUSY -> WAIT_DONE when tx_busy==1; -> IDLE if tx_busy stays 0 for 16 consecutive cycles in this state (timeout, byte considered sent).
REQ-025 WAIT_DONE -> IDLE when tx_busy==0.
REQ-026 tx_en SHALL be 0 in every state except START; at most one tx_en per popped byte.
REQ-027 Latency: push at edge E0 into empty FIFO with FSM IDLE and tx_busy=0 -> LOAD at E1, START at E2, tx_en high between E2 and E3.
REQ-028 Pushes SHALL be accepted in every FSM state.

Reset
REQ-029 While rst=1: FSM=IDLE, tx_en=0, tx_data=0x00, fifo_cnt=0, pointers=0, overflow=0, edge register=0, timeout counter=0.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered bytes; after release no tx_en until a new push.
REQ-031 First push SHALL be detectable on the first edge after rst falls if rx_done=1 there.

Verification
REQ-032 Single byte: push 0x5A, tx_busy high 1 cycle after tx_en for 10 cycles -> one tx_en 2 cycles after push, tx_data=0x5A, fifo_cnt 1->0, FSM back to IDLE.
REQ-033 Burst: 3 pushes 0x11,0x22,0x33 while tx_busy=1 -> fifo_cnt=3, then after tx_busy falls, three tx_en pulses in order 0x11,0x22,0x33.
REQ-034 Overflow: DEPTH+1 pushes with tx_busy=1 -> fifo_cnt=DEPTH, overflow=1, byte DEPTH+1 never transmitted; overflow stays 1 until reset.
REQ-035 Long rx_done: rx_done high 5 cycles with 0xA5 -> exactly one push, one tx_en.
REQ-036 Timeout: tx_busy held 0 after tx_en -> FSM IDLE after 16 cycles in WAIT_BUSY, next queued byte then issued.
REQ-037 Reset mid-operation: rst pulsed with fifo_cnt=2 in WAIT_DONE -> all outputs at reset values, no further tx_en.
